// File: rtl/sl_bus_arbiter.sv
// Round-robin arbiter for the shared slave bus: grants one eligible slave, streams its
// head frame as a valid/ready byte stream, then pulses sl_latch_tail to retire it.
module sl_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 256,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] sl_arb_request,
  output logic [NUM_REQ-1:0] sl_arb_grant,
  output logic [8:0]         sl_addr,
  input  logic [8:0]         sl_data,
  input  logic [8:0]         sl_tail,
  output logic               sl_latch_tail,
  input  logic [NUM_REQ-1:0] req_enable,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eof,
  output logic [SRC_W-1:0]   out_src,
  output logic               len_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN    = 3'd1;
  localparam logic [2:0] FETCH  = 3'd2;
  localparam logic [2:0] SHOW   = 3'd3;
  localparam logic [2:0] RETIRE = 3'd4;

  localparam logic [9:0] MAX_LEN_W = 10'(MAX_LEN);

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [8:0]         addr_q, addr_d;
  logic [8:0]         len_q, len_d;
  logic               len_err_q, len_err_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [SRC_W-1:0]   pick;
  int unsigned        idx;
  logic               show;
  logic               unused_sl_data8;

  assign unused_sl_data8 = sl_data[8];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    src_d     = src_q;
    rr_d      = rr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    len_err_d = 1'b0;
    eligible  = sl_arb_request & req_enable;
    found     = 1'b0;
    pick      = '0;
    idx       = 0;

    // Scan upward from rr_q with wrap; the first eligible slave wins.
    for (int unsigned i = 0; i < 32'(NUM_REQ); i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= 32'(NUM_REQ)) idx = idx - 32'(NUM_REQ);
      if (!found && eligible[SRC_W'(idx)]) begin
        found = 1'b1;
        pick  = SRC_W'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          src_d         = pick;
          addr_d        = '0;
          state_d       = LEN;
        end
      end
      LEN: begin
        len_d = sl_tail;
        if (sl_tail == 9'd0) begin
          state_d = RETIRE;
        end else if ({1'b0, sl_tail} > MAX_LEN_W) begin
          len_err_d = 1'b1;
          state_d   = RETIRE;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: state_d = SHOW;
      SHOW: begin
        if (out_ready) begin
          if (addr_q == len_q - 9'd1) begin
            state_d = RETIRE;
          end else begin
            addr_d  = addr_q + 9'd1;
            state_d = FETCH;
          end
        end
      end
      RETIRE: begin
        grant_d = '0;
        rr_d    = (src_q == SRC_W'(NUM_REQ - 1)) ? '0 : src_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      src_q     <= '0;
      rr_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      src_q     <= src_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end

  // Byte outputs follow the slave's registered read data while in SHOW; they stay
  // stable under backpressure because sl_addr is frozen there.
  assign show          = (state_q == SHOW);
  assign out_valid     = show;
  assign out_data      = show ? sl_data[7:0] : '0;
  assign out_sof       = show && (addr_q == 9'd0);
  assign out_eof       = show && (addr_q == len_q - 9'd1);
  assign out_src       = src_q;
  assign sl_arb_grant  = grant_q;
  assign sl_addr       = addr_q;
  assign sl_latch_tail = (state_q == RETIRE);
  assign len_err       = len_err_q;

endmodule

// File: doc/sl_bus_arbiter.md
Name: sl_bus_arbiter

Overview:
- Round-robin arbiter and read sequencer for the shared slave output bus (sl_data/sl_addr/sl_tail/sl_latch_tail).
- Grants one requesting slave at a time, such as a GPIO interrupt reporter or other message_fifo-backed sources.
- Drains that slave's head frame byte by byte onto a single valid/ready byte stream toward the host response path.
- Pulses sl_latch_tail to retire the frame, then re-arbitrates.

Parameters:
- NUM_REQ, 4: number of slave requesters; grant vector width.
- MAX_LEN, 256: frames with sl_tail greater than this are treated as errors, dropped, and flagged.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sl_arb_request  input  NUM_REQ  per-slave frame-available request.
- sl_arb_grant  output  NUM_REQ  one-hot grant; at most one bit set.
- sl_addr  output  9  byte offset within the granted frame, starting at 0.
- sl_data  input  9  granted slave's byte at sl_addr; [7:0] is used, [8] is ignored; valid 1 cycle after sl_addr changes.
- sl_tail  input  9  granted slave's head frame length in bytes; valid 1 cycle after grant.
- sl_latch_tail  output  1  one-cycle pulse that retires the granted slave's head frame.
- req_enable  input  NUM_REQ  per-slave mask; a masked request is never granted.
- out_data  output  8  streamed byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_sof  output  1  qualifies the first byte of a frame.
- out_eof  output  1  qualifies the last byte of a frame.
- out_src  output  log2(NUM_REQ)  index of the slave that owns the current frame.
- len_err  output  1  one-cycle pulse when a frame is dropped for sl_tail > MAX_LEN.

Behaviour:
- Reset values:
  - state=IDLE, sl_arb_grant=0, sl_addr=0, sl_latch_tail=0.
  - out_valid=0, out_sof=0, out_eof=0, out_data=0, out_src=0, len_err=0.
  - rr_ptr=0.
- Reset asserted mid-frame: everything returns to these values immediately. The frame is not retired; it is re-sent after reset.
- Eligible set = sl_arb_request & req_enable.
- Round-robin: pick the first eligible index scanning from rr_ptr upward with wrap. On retire, rr_ptr = granted index + 1, mod NUM_REQ.
- States:
  - IDLE: if any requester is eligible, register the one-hot grant and out_src, set sl_addr=0, go to LEN. Otherwise stay.
  - LEN: grant held; capture sl_tail into len.
    - len==0: go to RETIRE (empty frame, no bytes emitted).
    - len>MAX_LEN: pulse len_err, go to RETIRE.
    - Otherwise go to FETCH.
  - FETCH: one-cycle wait for registered slave read data; go to SHOW.
  - SHOW: out_valid=1, out_data=sl_data[7:0], out_sof=(sl_addr==0), out_eof=(sl_addr==len-1). Hold all outputs stable until out_ready.
    - On accept with sl_addr==len-1: go to RETIRE.
    - On accept otherwise: sl_addr+1, go to FETCH.
  - RETIRE: sl_latch_tail=1 for exactly one cycle with grant still held. Next cycle, grant=0 and state=IDLE.
- Throughput: 2 cycles per byte with out_ready tied high.
- Latency: request to first out_valid is 3 cycles (IDLE, LEN, FETCH).
- Grant never changes between IDLE exit and RETIRE completion.
- A request that drops during a grant is ignored; the frame is completed from the captured len.
- A request that rises during another grant waits; it is arbitrated only in IDLE.
- Re-arbitration after RETIRE takes at least 1 IDLE cycle, so the granted slave's request can update after the pop.
- sl_addr is 9 bits; len ≤ MAX_LEN ≤ 511 guarantees no wrap.
- out_ready asserted when out_valid=0 has no effect.

Test Plan:
- Single frame: slave 2 requests with tail=3, bytes 0x67, 0x05, 0xA1; out_ready=1.
  - Required: grant=4'b0100.
  - Three bytes emitted, sof on 0x67, eof on 0xA1, out_src=2.
  - One sl_latch_tail pulse, then grant=0.
- Round-robin fairness: all 4 requesting continuously, 1-byte frames.
  - Required: grant order 0,1,2,3,0,1.
  - Masking req_enable[1]=0 gives order 0,2,3,0.
- Backpressure: out_ready low 5 cycles mid-frame.
  - Required: out_data, sof and eof held stable, sl_addr unchanged.
  - No byte lost or duplicated.
- Empty and oversize frames:
  - tail=0: required zero out_valid, latch_tail pulse, no len_err.
  - tail=300 with MAX_LEN=256: required len_err pulse, latch_tail pulse, no out_valid.
- Reset mid-frame: assert reset after byte 1 of a 4-byte frame.
  - Required: all outputs reset asynchronously, no latch_tail.
  - After release, the frame re-streams from byte 0.
- Request churn: slave 0 drops its request during its grant while slave 3 raises one.
  - Required: slave 0 frame completes with its full length.
  - Slave 3 is granted only after RETIRE plus 1 IDLE cycle.
